// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
//
// Run controller for the pipelined MIPS core, used in simulation and during
// board bring-up. It holds the core in reset, releases it after a fixed
// number of cycles, and gates the core clock-enable in one of three run
// modes: free-run, run-N-cycles and single-step. It counts enabled cycles
// and ends a run when one of three things happens:
//   - the PC stops changing (a halt self-loop),
//   - the requested run length is reached, or
//   - a timeout expires.
// It reports which of these ended the run.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   start       in   begin a run (accepted only in IDLE or DONE)
//   mode        in   00 free-run, 01 run-N, 10 single-step, 11 = free-run
//   run_len     in   cycle budget for run-N
//   step        in   single-step request, rising edge detected
//   pc          in   core fetch-stage PC, valid in every enabled cycle
//   core_reset  out  reset to the core
//   core_en     out  clock-enable to the core
//   cycle_cnt   out  enabled cycles since core_reset was released
//   busy        out  high in RST, RUN and STEP_WAIT
//   done        out  high in DONE
//   done_cause  out  00 none, 01 halt loop, 10 run_len reached, 11 timeout
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
   parameter int RST_CYCLES  = 4,
   parameter int PC_W        = 32,
   parameter int CNT_W       = 32,
   parameter int MAX_CYCLES  = 10000,
   parameter int HALT_REPEAT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] run_len,
   input  logic             step,
   input  logic [PC_W-1:0]  pc,
   output logic             core_reset,
   output logic             core_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             busy,
   output logic             done,
   output logic [1:0]       done_cause
);

   localparam int RW     = $clog2(RST_CYCLES + 1);
   localparam int SAME_W = $clog2(HALT_REPEAT + 1);

   localparam logic [1:0] MODE_FREE  = 2'b00;
   localparam logic [1:0] MODE_RUN_N = 2'b01;
   localparam logic [1:0] MODE_STEP  = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_HALT    = 2'b01;
   localparam logic [1:0] CAUSE_LEN     = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_RUN,
      S_STEP_WAIT,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [1:0]         r_mode;
   logic [CNT_W-1:0]   r_run_len;
   logic [RW-1:0]      r_rst_cnt;
   logic               r_core_reset;
   logic               r_core_en;
   logic [CNT_W-1:0]   r_cycle_cnt;
   logic               r_busy;
   logic               r_done;
   logic [1:0]         r_cause;
   logic               r_step_d;
   logic [PC_W-1:0]    r_prev_pc;
   logic               r_prev_valid;
   logic [SAME_W-1:0]  r_same_cnt;

   logic               w_accept;
   logic               w_step_rise;
   logic               w_rst_last;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_pc_same;
   logic [SAME_W-1:0]  w_same_next;
   logic               w_halt;
   logic               w_len_hit;
   logic               w_timeout;
   logic               w_stop;
   logic [1:0]         w_cause;
   logic [1:0]         w_mode_norm;

   assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_step_rise = step && !r_step_d;
   assign w_rst_last  = (r_rst_cnt == RW'(RST_CYCLES - 1));

   // Mode 11 is folded into free-run when it is latched, so the rest of the
   // logic only ever sees the three real modes.
   assign w_mode_norm = (mode == MODE_RUN_N) ? MODE_RUN_N :
                        (mode == MODE_STEP)  ? MODE_STEP  : MODE_FREE;

   // Termination checks. They are evaluated on the count after this enabled
   // cycle, so the cycle that triggers a stop is counted and is the last one.
   assign w_cnt_next  = r_cycle_cnt + CNT_W'(1);
   assign w_pc_same   = r_prev_valid && (pc == r_prev_pc);
   assign w_same_next = w_pc_same ? (r_same_cnt + SAME_W'(1)) : '0;
   assign w_halt      = (w_same_next == SAME_W'(HALT_REPEAT));
   assign w_len_hit   = (r_mode == MODE_RUN_N) && (w_cnt_next == r_run_len);
   assign w_timeout   = (w_cnt_next == CNT_W'(MAX_CYCLES));
   assign w_stop      = w_halt || w_len_hit || w_timeout;

   // When several causes fire together, halt wins, then run length, then
   // timeout.
   assign w_cause = w_halt    ? CAUSE_HALT :
                    w_len_hit ? CAUSE_LEN  : CAUSE_TIMEOUT;

   // NOTE: all state below uses non-blocking assignments so every register
   // sees the pre-edge values of the others, whatever the statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_mode       <= MODE_FREE;
         r_run_len    <= '0;
         r_rst_cnt    <= '0;
         r_core_reset <= 1'b1;
         r_core_en    <= 1'b0;
         r_cycle_cnt  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cause      <= CAUSE_NONE;
         r_step_d     <= 1'b0;
         r_prev_pc    <= '0;
         r_prev_valid <= 1'b0;
         r_same_cnt   <= '0;
      end else begin
         // The step history is tracked in every state. An edge that lands in
         // the last RST cycle is therefore consumed there and never reaches
         // STEP_WAIT.
         r_step_d <= step;

         // Bookkeeping for any enabled cycle, in RUN or STEP_WAIT alike.
         if (r_core_en) begin
            r_cycle_cnt  <= w_cnt_next;
            r_prev_pc    <= pc;
            r_prev_valid <= 1'b1;
            r_same_cnt   <= w_same_next;
         end

         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_state      <= S_RST;
                  r_mode       <= w_mode_norm;
                  r_run_len    <= run_len;
                  r_rst_cnt    <= '0;
                  r_cycle_cnt  <= '0;
                  r_cause      <= CAUSE_NONE;
                  r_same_cnt   <= '0;
                  r_prev_valid <= 1'b0;
                  r_core_reset <= 1'b1;
                  r_core_en    <= 1'b0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
               end
            end

            S_RST: begin
               r_rst_cnt <= r_rst_cnt + RW'(1);
               if (w_rst_last) begin
                  r_core_reset <= 1'b0;
                  if ((r_mode == MODE_RUN_N) && (r_run_len == '0)) begin
                     // A zero budget ends the run without a single enabled
                     // cycle.
                     r_state <= S_DONE;
                     r_cause <= CAUSE_LEN;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (r_mode == MODE_STEP) begin
                     r_state <= S_STEP_WAIT;
                  end else begin
                     r_state   <= S_RUN;
                     r_core_en <= 1'b1;
                  end
               end
            end

            S_RUN: begin
               if (w_stop) begin
                  r_state   <= S_DONE;
                  r_core_en <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_cause   <= w_cause;
               end
            end

            S_STEP_WAIT: begin
               if (r_core_en) begin
                  // Each step grants exactly one enabled cycle.
                  r_core_en <= 1'b0;
                  if (w_stop) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_cause <= w_cause;
                  end
               end else if (w_step_rise) begin
                  r_core_en <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign core_reset = r_core_reset;
   assign core_en    = r_core_en;
   assign cycle_cnt  = r_cycle_cnt;
   assign busy       = r_busy;
   assign done       = r_done;
   assign done_cause = r_cause;

   // Structural invariants of the controller.
   a_busy_done_excl : assert property (@(posedge clk) disable iff (reset)
      !(r_busy && r_done));
   a_en_only_running : assert property (@(posedge clk) disable iff (reset)
      r_core_en |-> ((r_state == S_RUN) || (r_state == S_STEP_WAIT)));

endmodule

// File: tb/tb_mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_run_ctrl
//
// Self-checking bench for mips_run_ctrl, built with a short timeout.
// Each test pushes the outcome it expects for a run (done_cause,
// final cycle_cnt and the number of core_en cycles) into a scoreboard
// queue. run_to_done then pops that entry when the DUT raises done and
// compares it against what the DUT actually did.
// -----------------------------------------------------------------------------
module tb_mips_run_ctrl;

   localparam int RST_CYCLES  = 4;
   localparam int PC_W        = 32;
   localparam int CNT_W       = 32;
   localparam int MAX_CYCLES  = 20;
   localparam int HALT_REPEAT = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [CNT_W-1:0] run_len = '0;
   logic             step = 1'b0;
   logic [PC_W-1:0]  pc = '0;
   logic             core_reset;
   logic             core_en;
   logic [CNT_W-1:0] cycle_cnt;
   logic             busy;
   logic             done;
   logic [1:0]       done_cause;

   typedef struct {
      logic [1:0]       cause;
      logic [CNT_W-1:0] cnt;
      int               en_cycles;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   stuck_from = 0;   // enabled cycle from which pc stops advancing (0 = never)

   mips_run_ctrl #(
      .RST_CYCLES (RST_CYCLES),
      .PC_W       (PC_W),
      .CNT_W      (CNT_W),
      .MAX_CYCLES (MAX_CYCLES),
      .HALT_REPEAT(HALT_REPEAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .run_len   (run_len),
      .step      (step),
      .pc        (pc),
      .core_reset(core_reset),
      .core_en   (core_en),
      .cycle_cnt (cycle_cnt),
      .busy      (busy),
      .done      (done),
      .done_cause(done_cause)
   );

   always #5 clk = ~clk;

   // PC presented in enabled cycle k (1-based): 0x3000 + 4*(k-1), frozen
   // from enabled cycle stuck_from onward.
   function automatic logic [PC_W-1:0] pc_for(input int k);
      int idx;
      idx = (stuck_from > 0 && k >= stuck_from) ? stuck_from : k;
      return PC_W'(32'h3000 + 4 * (idx - 1));
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      step  = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Present start for one edge, then scramble mode/run_len so that any use
   // of the live inputs instead of the latched ones shows up.
   task automatic do_start(input logic [1:0] m, input logic [CNT_W-1:0] len);
      @(negedge clk);
      mode    = m;
      run_len = len;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      mode    = 2'b01;
      run_len = CNT_W'(1);
   endtask

   // Monitor a run until done; drive pc in enabled cycles; optionally pulse
   // start (with hostile mode/run_len) after enabled cycle pulse_at. On done,
   // pop the scoreboard and compare.
   task automatic run_to_done(input string name, input int budget, input int pulse_at);
      int   en_n = 0;
      int   rst_n = 0;
      bit   overlap = 1'b0;
      bit   finished = 1'b0;
      exp_t e;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy && done) overlap = 1'b1;
         if (done) begin
            finished = 1'b1;
            break;
         end
         if (core_reset) rst_n++;
         if (core_en) begin
            en_n++;
            pc = pc_for(en_n);
            if (en_n == pulse_at) begin
               start   = 1'b1;
               mode    = 2'b01;
               run_len = CNT_W'(1);
            end
         end
      end
      start = 1'b0;
      n_tests++;
      if (!finished) begin
         n_fail++;
         $display("FAIL %s done_wait: done not seen within %0d cycles", name, budget);
         return;
      end
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s scoreboard: no expectation queued", name);
         return;
      end
      e = sb.pop_front();
      n_tests++; if (en_n !== e.en_cycles) begin n_fail++; $display("FAIL %s en_cycles: got %0d want %0d", name, en_n, e.en_cycles); end
      n_tests++; if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL %s cycle_cnt: got %0d want %0d", name, cycle_cnt, e.cnt); end
      n_tests++; if (done_cause !== e.cause) begin n_fail++; $display("FAIL %s done_cause: got %b want %b", name, done_cause, e.cause); end
      n_tests++; if (rst_n !== RST_CYCLES) begin n_fail++; $display("FAIL %s core_reset_len: got %0d want %0d", name, rst_n, RST_CYCLES); end
      n_tests++; if ({busy, core_en, core_reset} !== 3'b000) begin n_fail++; $display("FAIL %s done_outputs busy/en/rst: got %b want 000", name, {busy, core_en, core_reset}); end
      n_tests++; if (overlap !== 1'b0) begin n_fail++; $display("FAIL %s busy_done_overlap: got 1 want 0", name); end
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL reset core_reset: got %b want 1", core_reset); end
      n_tests++; if (core_en !== 1'b0) begin n_fail++; $display("FAIL reset core_en: got %b want 0", core_en); end
      n_tests++; if (cycle_cnt !== '0) begin n_fail++; $display("FAIL reset cycle_cnt: got %0d want 0", cycle_cnt); end
      n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset busy/done: got %b want 00", {busy, done}); end
      n_tests++; if (done_cause !== 2'b00) begin n_fail++; $display("FAIL reset done_cause: got %b want 00", done_cause); end
      repeat (3) @(negedge clk);
      n_tests++; if ({core_reset, core_en, busy} !== 3'b100) begin n_fail++; $display("FAIL idle_hold rst/en/busy: got %b want 100", {core_reset, core_en, busy}); end
   endtask

   task automatic test_free_run_timeout();
      do_reset();
      stuck_from = 0;
      sb.push_back('{2'b11, CNT_W'(20), 20});
      do_start(2'b00, '0);
      run_to_done("free_run", 200, 0);
   endtask

   task automatic test_run_n();
      do_reset();
      stuck_from = 0;
      sb.push_back('{2'b10, CNT_W'(7), 7});
      do_start(2'b01, CNT_W'(7));
      run_to_done("run_n7", 200, 0);
      // Zero budget, restarted straight from DONE.
      sb.push_back('{2'b10, CNT_W'(0), 0});
      do_start(2'b01, '0);
      run_to_done("run_n0", 200, 0);
   endtask

   task automatic test_halt_loop();
      do_reset();
      stuck_from = 4;
      // Mode 11 must act as free-run: the run_len of 5 must be ignored.
      sb.push_back('{2'b01, CNT_W'(7), 7});
      do_start(2'b11, CNT_W'(5));
      run_to_done("halt", 200, 0);
      stuck_from = 0;
   endtask

   task automatic test_single_step();
      int   en_n = 0;
      bit   flags_ok = 1'b1;
      exp_t e;
      do_reset();
      stuck_from = 0;
      sb.push_back('{2'b00, CNT_W'(3), 3});
      do_start(2'b10, '0);
      // Iteration i drives step for the cycle ending at edge i after the
      // start edge. i=4 is the last RST cycle and must be ignored; then a
      // 5-cycle hold and two single-cycle pulses.
      for (int i = 1; i <= 26; i++) begin
         @(negedge clk);
         if (!busy || done) flags_ok = 1'b0;
         if (core_en) begin
            en_n++;
            pc = pc_for(en_n);
         end
         step = (i == 4) || (i >= 8 && i <= 12) || (i == 16) || (i == 20);
      end
      step = 1'b0;
      e = sb.pop_front();
      n_tests++; if (en_n !== e.en_cycles) begin n_fail++; $display("FAIL step en_cycles: got %0d want %0d", en_n, e.en_cycles); end
      n_tests++; if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL step cycle_cnt: got %0d want %0d", cycle_cnt, e.cnt); end
      n_tests++; if (done_cause !== e.cause) begin n_fail++; $display("FAIL step done_cause: got %b want %b", done_cause, e.cause); end
      n_tests++; if (flags_ok !== 1'b1) begin n_fail++; $display("FAIL step busy/done: got a cycle with busy=0 or done=1, want busy=1 done=0"); end
   endtask

   task automatic test_start_while_busy();
      do_reset();
      stuck_from = 0;
      // A start (with mode 01, run_len 1) during RUN must not restart or
      // re-latch; the run still times out.
      sb.push_back('{2'b11, CNT_W'(20), 20});
      do_start(2'b00, '0);
      run_to_done("start_busy", 200, 3);
   endtask

   task automatic test_reset_midrun();
      int en_n = 0;
      bit reached = 1'b0;
      do_reset();
      stuck_from = 0;
      do_start(2'b00, '0);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (core_en) begin
            en_n++;
            pc = pc_for(en_n);
         end
         if (cycle_cnt == CNT_W'(5)) begin
            reached = 1'b1;
            break;
         end
      end
      n_tests++; if (reached !== 1'b1) begin n_fail++; $display("FAIL midrun reach_cnt5: got 0 want 1"); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_tests++; if ({core_reset, core_en} !== 2'b10) begin n_fail++; $display("FAIL midrun rst/en: got %b want 10", {core_reset, core_en}); end
      n_tests++; if (cycle_cnt !== '0) begin n_fail++; $display("FAIL midrun cycle_cnt: got %0d want 0", cycle_cnt); end
      n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL midrun busy/done: got %b want 00", {busy, done}); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      stuck_from = 4;
      sb.push_back('{2'b01, CNT_W'(7), 7});
      do_start(2'b01, CNT_W'(7));
      run_to_done("halt_and_len", 200, 0);
      stuck_from = 0;
      // Restart from DONE: counters and cause clear on the accept edge.
      sb.push_back('{2'b10, CNT_W'(3), 3});
      do_start(2'b01, CNT_W'(3));
      n_tests++; if (cycle_cnt !== '0) begin n_fail++; $display("FAIL restart cycle_cnt: got %0d want 0", cycle_cnt); end
      n_tests++; if (done_cause !== 2'b00) begin n_fail++; $display("FAIL restart done_cause: got %b want 00", done_cause); end
      n_tests++; if ({core_reset, busy, done} !== 3'b110) begin n_fail++; $display("FAIL restart rst/busy/done: got %b want 110", {core_reset, busy, done}); end
      run_to_done("restart_run", 200, 0);
   endtask

   initial begin
      test_reset();
      test_free_run_timeout();
      test_run_n();
      test_halt_loop();
      test_single_step();
      test_start_while_busy();
      test_reset_midrun();
      test_simultaneous();
      n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Synthesizable run controller that sequences the pipelined MIPS core for simulation and board bring-up.
- Generates the core's reset pulse and a clock-enable.
- Supports three run modes: free-run, run-N-cycles and single-step.
- Counts executed cycles and ends a run on a halt self-loop (stable PC), on run-length reached, or on timeout; reports which one.

Parameters:
- RST_CYCLES, 4: number of cycles core_reset is held high after a start; must be ≥1.
- PC_W, 32: width of the observed PC.
- CNT_W, 32: width of the cycle counter and run_len.
- MAX_CYCLES, 10000: timeout in enabled cycles; must be ≤ 2^CNT_W-1.
- HALT_REPEAT, 3: number of consecutive equal-PC comparisons that declare a halt; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- mode  in  2  run mode: 00 free-run, 01 run-N, 10 single-step, 11 treated as 00; latched on an accepted start.
- run_len  in  CNT_W  cycle budget for mode 01; latched on an accepted start.
- step  in  1  single-step request; rising edge detected.
- pc  in  PC_W  core fetch-stage PC, valid in every enabled cycle.
- core_reset  out  1  reset to the core.
- core_en  out  1  clock-enable to the core.
- cycle_cnt  out  CNT_W  enabled cycles since core_reset was released.
- busy  out  1  high in RST, RUN and STEP_WAIT.
- done  out  1  high in DONE.
- done_cause  out  2  00 none, 01 halt loop, 10 run_len reached, 11 timeout.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values and outcome: next state IDLE; core_reset=1, core_en=0, cycle_cnt=0, busy=0, done=0, done_cause=00; step edge register, prev_pc and same_cnt all cleared.
- Reset asserted in any state, including mid-run, gives the reset values on the next edge and abandons the run.

States and transitions:
- IDLE: core_reset=1, core_en=0. An accepted start goes to RST.
- RST:
  - Duration: exactly RST_CYCLES cycles with core_reset=1.
  - On entry: clear cycle_cnt, done_cause, same_cnt and the prev_pc-valid flag.
  - Exit: to STEP_WAIT if the latched mode is 10, otherwise to RUN; core_reset=0 from the exit cycle onward.
- Special case, mode 01 with run_len=0: RST goes directly to DONE with done_cause=10 and zero enabled cycles.
- RUN:
  - core_en=1 every cycle.
  - cycle_cnt is incremented by 1 in each enabled cycle.
- STEP_WAIT:
  - core_en=0 except for exactly one cycle per rising edge of step.
  - step held high counts as a single step.
  - A step rising edge in the last RST cycle is ignored.

Termination checks (in each enabled cycle, on the post-increment count n):
- Halt: if the prev_pc-valid flag is set and pc==prev_pc, same_cnt+1, otherwise same_cnt=0.
  - prev_pc<=pc and the valid flag is set after every enabled cycle.
  - Halt is declared when same_cnt reaches HALT_REPEAT.
- Run length: mode 01 and n==run_len.
- Timeout: n==MAX_CYCLES, checked in every mode.
- Any termination: the next state is DONE and the enabled cycle that triggered it is the last one.
- Simultaneous causes, priority: halt(01) > run_len(10) > timeout(11).
- DONE:
  - core_en=0, core_reset=0 (core state held for inspection).
  - done=1, busy=0.
  - cycle_cnt and done_cause are held.
  - An accepted start goes to RST, which clears the counters and done_cause.
- start while busy is ignored; mode and run_len changes while busy are ignored.
- busy and done are never high together.

Test Plan:
- Bench setup: RST_CYCLES=4, HALT_REPEAT=3, MAX_CYCLES=20.
1. Free-run timeout:
   - Stimulus: reset, then start with mode=00; pc increments by 4 from 0x3000.
   - Required: core_reset stays high 4 cycles after the start-acceptance edge; core_en is high for exactly 20 cycles; then done=1, done_cause=11, cycle_cnt=20.
2. Run-N:
   - Stimulus: mode=01, run_len=7, pc incrementing.
   - Required: exactly 7 core_en cycles; cycle_cnt=7, done_cause=10.
   - Also: run_len=0 enters DONE directly from RST with cycle_cnt=0 and done_cause=10.
3. Halt loop:
   - Stimulus: mode=00; pc sequence 0x3000, 0x3004, 0x3008, then 0x300c repeated.
   - Required: done after the 7th enabled cycle; cycle_cnt=7, done_cause=01.
4. Single-step:
   - Stimulus: mode=10; step held high for 5 cycles, then two 1-cycle pulses.
   - Required: core_en is high for exactly 3 cycles in total; cycle_cnt=3; busy=1 and done=0 throughout.
5. Reset mid-run and start while busy:
   - Stimulus: assert reset in RUN at cycle_cnt=5.
   - Required on the next edge: core_reset=1, core_en=0, cycle_cnt=0, busy=0.
   - Separately: pulse start while in RUN; the run proceeds with no state change.
6. Simultaneous causes:
   - Stimulus: mode=01, run_len=7; pc stuck from enabled cycle 4 onward.
   - Required: halt and run_len coincide at cycle 7; done_cause=01.
   - Then: start again; cycle_cnt and done_cause clear, and core_reset pulses for 4 cycles.
